fanfare_piezo_drv: RTL and testbench

//  Piezo tone sequencer downstream of the Knight's Tour command processor.
//  A 1-cycle fanfare request plays a fixed six-note charge melody on a

---
 rtl/fanfare_piezo_drv.sv | 160 ++++++++++++++++
 tb/tb_fanfare_piezo_drv.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/fanfare_piezo_drv.sv
// Six-note charge fanfare (G6 C7 E7 G7 E7 G7) on a differential piezo pair.
// Define FAST_SIM_EN to shorten the note unit 16x for simulation; periods unchanged.
module fanfare_piezo_drv #(
  parameter int unsigned G6_PER    = 31888,
  parameter int unsigned C7_PER    = 23889,
  parameter int unsigned E7_PER    = 18961,
  parameter int unsigned G7_PER    = 15944,
  parameter int unsigned UNIT_LOG2 = 22
) (
  input  logic clk,
  input  logic rst_n,
  input  logic go,
  output logic piezo,
  output logic piezo_n,
  output logic busy,
  output logic done
);

  localparam int unsigned DUR_W  = 25;
  localparam int unsigned TONE_W = 15;

`ifdef FAST_SIM_EN
  localparam int unsigned UNIT_SH = UNIT_LOG2 - 4;
`else
  localparam int unsigned UNIT_SH = UNIT_LOG2;
`endif

  // Terminal counts for note lengths of 1..4 units
  localparam logic [DUR_W-1:0] TERM_1 = DUR_W'((64'd1 << UNIT_SH) - 64'd1);
  localparam logic [DUR_W-1:0] TERM_2 = DUR_W'((64'd2 << UNIT_SH) - 64'd1);
  localparam logic [DUR_W-1:0] TERM_3 = DUR_W'((64'd3 << UNIT_SH) - 64'd1);
  localparam logic [DUR_W-1:0] TERM_4 = DUR_W'((64'd4 << UNIT_SH) - 64'd1);

  localparam logic [TONE_W-1:0] PER_G6  = TONE_W'(G6_PER);
  localparam logic [TONE_W-1:0] PER_C7  = TONE_W'(C7_PER);
  localparam logic [TONE_W-1:0] PER_E7  = TONE_W'(E7_PER);
  localparam logic [TONE_W-1:0] PER_G7  = TONE_W'(G7_PER);
  localparam logic [TONE_W-1:0] HALF_G6 = TONE_W'(G6_PER / 2);
  localparam logic [TONE_W-1:0] HALF_C7 = TONE_W'(C7_PER / 2);
  localparam logic [TONE_W-1:0] HALF_E7 = TONE_W'(E7_PER / 2);
  localparam logic [TONE_W-1:0] HALF_G7 = TONE_W'(G7_PER / 2);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    N0   = 3'd1,
    N1   = 3'd2,
    N2   = 3'd3,
    N3   = 3'd4,
    N4   = 3'd5,
    N5   = 3'd6
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [DUR_W-1:0]    dur_cnt;
  logic [DUR_W-1:0]    dur_cnt_nxt;
  logic [TONE_W-1:0]   tone_cnt;
  logic [TONE_W-1:0]   tone_cnt_nxt;
  logic                term_hit;
  logic                piezo_d;
  logic                piezo_n_d;
  logic                busy_d;
  logic                done_d;

  function automatic logic [TONE_W-1:0] note_per(input state_t s);
    case (s)
      N0:      return PER_G6;
      N1:      return PER_C7;
      N2:      return PER_E7;
      N3:      return PER_G7;
      N4:      return PER_E7;
      N5:      return PER_G7;
      default: return PER_G6;
    endcase
  endfunction

  function automatic logic [TONE_W-1:0] note_half(input state_t s);
    case (s)
      N0:      return HALF_G6;
      N1:      return HALF_C7;
      N2:      return HALF_E7;
      N3:      return HALF_G7;
      N4:      return HALF_E7;
      N5:      return HALF_G7;
      default: return '0;
    endcase
  endfunction

  function automatic logic [DUR_W-1:0] note_term(input state_t s);
    case (s)
      N0, N1, N2: return TERM_2;
      N3:         return TERM_3;
      N4:         return TERM_1;
      N5:         return TERM_4;
      default:    return '0;
    endcase
  endfunction

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      dur_cnt  <= '0;
      tone_cnt <= '0;
      piezo    <= 1'b0;
      piezo_n  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      dur_cnt  <= dur_cnt_nxt;
      tone_cnt <= tone_cnt_nxt;
      piezo    <= piezo_d;
      piezo_n  <= piezo_n_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  // Next state: go only matters in IDLE; each note ends on its terminal count
  always_comb begin
    state_nxt = state;
    term_hit  = (state != IDLE) && (dur_cnt == note_term(state));
    case (state)
      IDLE:    if (go)       state_nxt = N0;
      N0:      if (term_hit) state_nxt = N1;
      N1:      if (term_hit) state_nxt = N2;
      N2:      if (term_hit) state_nxt = N3;
      N3:      if (term_hit) state_nxt = N4;
      N4:      if (term_hit) state_nxt = N5;
      N5:      if (term_hit) state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // Counters restart on every note entry so each note begins with a fresh phase
  always_comb begin
    dur_cnt_nxt  = '0;
    tone_cnt_nxt = '0;
    if ((state_nxt == state) && (state != IDLE)) begin
      dur_cnt_nxt  = dur_cnt + DUR_W'(1);
      tone_cnt_nxt = (tone_cnt == note_per(state) - TONE_W'(1)) ? '0 : tone_cnt + TONE_W'(1);
    end
  end

  // Output values for the coming cycle, derived from next state and next tone phase
  always_comb begin
    piezo_d   = 1'b0;
    piezo_n_d = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    if (state_nxt != IDLE) begin
      busy_d    = 1'b1;
      piezo_d   = (tone_cnt_nxt < note_half(state_nxt));
      piezo_n_d = ~piezo_d;
    end
    done_d = (state == N5) && term_hit;
  end

endmodule

// File: tb/tb_fanfare_piezo_drv.sv
// Scoreboard bench for fanfare_piezo_drv with shortened periods and unit.
module tb_fanfare_piezo_drv;

  localparam int unsigned TB_UL = 8;
`ifdef FAST_SIM_EN
  localparam int U = 1 << (TB_UL - 4);
`else
  localparam int U = 1 << TB_UL;
`endif
  localparam int MEL = 14 * U;

  logic clk;
  logic rst_n;
  logic go;
  logic piezo;
  logic piezo_n;
  logic busy;
  logic done;

  typedef struct {
    logic [3:0] v;
    int         mel;
    int         k;
  } exp_t;

  exp_t q[$];
  int   vectors;
  int   miscompares;
  int   mel_id;
  int   per_tab[6];
  int   cum_tab[7];

  fanfare_piezo_drv #(
    .G6_PER   (13),
    .C7_PER   (10),
    .E7_PER   (8),
    .G7_PER   (6),
    .UNIT_LOG2(TB_UL)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .go     (go),
    .piezo  (piezo),
    .piezo_n(piezo_n),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {piezo,piezo_n,busy,done} k cycles after the go edge (k=1 first busy cycle)
  function automatic logic [3:0] exp_at(input int k);
    int off;
    int idx;
    int ph;
    logic p;
    if (k >= 1 && k <= MEL) begin
      off = k - 1;
      idx = 0;
      for (int i = 0; i < 6; i++)
        if (off >= cum_tab[i] * U) idx = i;
      ph = (off - cum_tab[idx] * U) % per_tab[idx];
      p  = (ph < per_tab[idx] / 2);
      return {p, ~p, 1'b1, 1'b0};
    end
    if (k == MEL + 1) return 4'b0001;
    return 4'b0000;
  endfunction

  task automatic push_melody(input int last_k);
    exp_t e;
    mel_id++;
    for (int k = 1; k <= last_k; k++) begin
      e.v = exp_at(k); e.mel = mel_id; e.k = k;
      q.push_back(e);
    end
  endtask

  task automatic push_idle(input int n);
    exp_t e;
    for (int k = 1; k <= n; k++) begin
      e.v = 4'b0000; e.mel = 0; e.k = k;
      q.push_back(e);
    end
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s {piezo,piezo_n,busy,done} obs=%b exp=%b", tag, obs, expv);
    end
  endtask

  // Pop and compare one entry per cycle; raise go after cycles ga/gb
  task automatic drain(input int n, input int ga, input int gb);
    exp_t e;
    for (int j = 1; j <= n; j++) begin
      @(negedge clk);
      if (q.size() == 0) begin
        check("queue_underrun", {piezo, piezo_n, busy, done}, 4'bxxxx);
      end else begin
        e = q.pop_front();
        check($sformatf("mel%0d_k%0d", e.mel, e.k), {piezo, piezo_n, busy, done}, e.v);
      end
      go = (j == ga) || (j == gb);
    end
    go = 1'b0;
  endtask

  initial begin
    per_tab = '{13, 10, 8, 6, 8, 6};
    cum_tab = '{0, 2, 4, 6, 9, 10, 14};
    vectors = 0;
    miscompares = 0;
    mel_id = 0;
    go = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 check("reset_values", {piezo, piezo_n, busy, done}, 4'b0000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle with no go: silent
    push_idle(300);
    drain(300, -1, -1);

    // Full melody
    @(negedge clk); go = 1'b1;
    push_melody(MEL + 6);
    drain(MEL + 6, -1, -1);

    // Extra go pulses during N1 and N4 are ignored
    @(negedge clk); go = 1'b1;
    push_melody(MEL + 6);
    drain(MEL + 6, 2 * U + 4, 9 * U + 3);

    // Async reset during N3, silence afterwards, then a fresh start
    @(negedge clk); go = 1'b1;
    push_melody(6 * U + 5);
    drain(6 * U + 5, -1, -1);
    rst_n = 1'b0;
    #1 check("async_reset", {piezo, piezo_n, busy, done}, 4'b0000);
    repeat (3) @(negedge clk);
    check("reset_hold", {piezo, piezo_n, busy, done}, 4'b0000);
    rst_n = 1'b1;
    vectors++;
    assert (q.size() == 0) else begin
      miscompares++;
      $error("FAIL queue_empty obs=%0d exp=0", q.size());
    end
    push_idle(50);
    drain(50, -1, -1);
    @(negedge clk); go = 1'b1;
    push_melody(MEL + 6);
    drain(MEL + 6, -1, -1);

    // go on N5 terminal cycle ignored; go one cycle later replays
    @(negedge clk); go = 1'b1;
    push_melody(MEL + 1);
    push_melody(MEL + 8);
    drain(2 * MEL + 9, MEL, MEL + 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
